// File: rtl/stepper_pulse_driver_pkg.sv
// Shared types and default timing for the stepper pulse driver and its controller.
package stepper_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, RUN} stepper_state_t;

   localparam int unsigned STEPS_W         = 8;
   localparam int unsigned STEP_PERIOD_DEF = 2500;
   localparam int unsigned PULSE_HIGH_DEF  = 100;
   localparam int unsigned DIR_SETUP_DEF   = 50;

endpackage

// File: rtl/stepper_pulse_driver_if.sv
// Controller <-> stepper driver handshake and motor pin bundle.
interface stepper_pulse_driver_if;
   import stepper_pkg::*;

   logic               dataReady;
   logic [STEPS_W-1:0] steps1;
   logic [STEPS_W-1:0] steps2;
   logic               dir1;
   logic               dir2;
   logic               enable;
   logic               stepperReady;
   logic               step1Pin;
   logic               step2Pin;
   logic               dir1Pin;
   logic               dir2Pin;

   modport master (
      output dataReady, steps1, steps2, dir1, dir2, enable,
      input  stepperReady, step1Pin, step2Pin, dir1Pin, dir2Pin
   );

   modport slave (
      input  dataReady, steps1, steps2, dir1, dir2, enable,
      output stepperReady, step1Pin, step2Pin, dir1Pin, dir2Pin
   );

endinterface

// File: rtl/stepper_pulse_driver_channel.sv
// One motor channel: remaining-step count, registered direction and step pin.
module step_channel
   import stepper_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [STEPS_W-1:0] steps_in,
   input  logic               dir_in,
   input  logic               period_start,
   input  logic               pulse_end,
   output logic               step_pin,
   output logic               dir_pin,
   output logic               rem_zero
);

   logic [STEPS_W-1:0] rem_q, rem_d;
   logic               step_q, step_d;
   logic               dir_q, dir_d;

   always_comb begin
      rem_d  = rem_q;
      step_d = step_q;
      dir_d  = dir_q;
      if (load) begin
         rem_d = steps_in;
         dir_d = dir_in;
      end
      // a channel that has used up its count sits out the remaining periods
      if (period_start && (rem_q != '0)) begin
         step_d = 1'b1;
         rem_d  = rem_q - STEPS_W'(1);
      end
      if (pulse_end) begin
         step_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q  <= '0;
         step_q <= 1'b0;
         dir_q  <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         step_q <= step_d;
         dir_q  <= dir_d;
      end
   end

   assign step_pin = step_q;
   assign dir_pin  = dir_q;
   assign rem_zero = (rem_q == '0);

endmodule

// File: rtl/stepper_pulse_driver.sv
// Two-motor step/dir pulse generator; accepts one move per handshake and reports idle.
//  state | meaning
//  IDLE  | stepperReady high, waiting for dataReady
//  SETUP | dir pins settling before the first step edge
//  RUN   | period counter running, channels pulse at each period start
module stepper_pulse_driver
   import stepper_pkg::*;
#(
   parameter int unsigned STEP_PERIOD = STEP_PERIOD_DEF,
   parameter int unsigned PULSE_HIGH  = PULSE_HIGH_DEF,
   parameter int unsigned DIR_SETUP   = DIR_SETUP_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   stepper_pulse_driver_if.slave bus
);

   localparam int unsigned PER_W = $clog2(STEP_PERIOD);
   localparam int unsigned SET_W = $clog2(DIR_SETUP + 1);
   localparam int unsigned PUL_W = $clog2(PULSE_HIGH + 1);
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(STEP_PERIOD - 1);
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(DIR_SETUP - 1);
   localparam logic [PUL_W-1:0] PUL_LOAD = PUL_W'(PULSE_HIGH - 1);

   stepper_state_t   state_q, state_d;
   logic [PER_W-1:0] period_cnt_q, period_cnt_d;
   logic [SET_W-1:0] setup_cnt_q, setup_cnt_d;
   logic [PUL_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic             pulse_busy_q, pulse_busy_d;
   logic             ready_q, ready_d;
   logic             load, period_start, pulse_end;
   logic             rem1_zero, rem2_zero, all_done;

   assign all_done = rem1_zero & rem2_zero;

   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      setup_cnt_d  = setup_cnt_q;
      ready_d      = ready_q;
      load         = 1'b0;
      period_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.dataReady) begin
               load        = 1'b1;
               ready_d     = 1'b0;
               setup_cnt_d = SET_LOAD;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            if (bus.enable) begin
               if (setup_cnt_q == '0) begin
                  if (all_done) begin
                     state_d = IDLE;
                     ready_d = 1'b1;
                  end else begin
                     state_d      = RUN;
                     period_cnt_d = '0;
                     period_start = 1'b1;
                  end
               end else begin
                  setup_cnt_d = setup_cnt_q - SET_W'(1);
               end
            end
         end
         RUN: begin
            if (bus.enable) begin
               if (period_cnt_q == PER_LAST) begin
                  if (all_done) begin
                     state_d = IDLE;
                     ready_d = 1'b1;
                  end else begin
                     period_cnt_d = '0;
                     period_start = 1'b1;
                  end
               end else begin
                  period_cnt_d = period_cnt_q + PER_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // pulse width runs off its own timer so a pause never shortens a pulse in flight
   always_comb begin
      pulse_busy_d = pulse_busy_q;
      pulse_cnt_d  = pulse_cnt_q;
      pulse_end    = 1'b0;
      if (pulse_busy_q) begin
         if (pulse_cnt_q == '0) begin
            pulse_end    = 1'b1;
            pulse_busy_d = 1'b0;
         end else begin
            pulse_cnt_d = pulse_cnt_q - PUL_W'(1);
         end
      end
      if (period_start) begin
         pulse_busy_d = 1'b1;
         pulse_cnt_d  = PUL_LOAD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         period_cnt_q <= '0;
         setup_cnt_q  <= '0;
         pulse_cnt_q  <= '0;
         pulse_busy_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         setup_cnt_q  <= setup_cnt_d;
         pulse_cnt_q  <= pulse_cnt_d;
         pulse_busy_q <= pulse_busy_d;
         ready_q      <= ready_d;
      end
   end

   step_channel u_ch1 (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .steps_in     (bus.steps1),
      .dir_in       (bus.dir1),
      .period_start (period_start),
      .pulse_end    (pulse_end),
      .step_pin     (bus.step1Pin),
      .dir_pin      (bus.dir1Pin),
      .rem_zero     (rem1_zero)
   );

   step_channel u_ch2 (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .steps_in     (bus.steps2),
      .dir_in       (bus.dir2),
      .period_start (period_start),
      .pulse_end    (pulse_end),
      .step_pin     (bus.step2Pin),
      .dir_pin      (bus.dir2Pin),
      .rem_zero     (rem2_zero)
   );

   assign bus.stepperReady = ready_q;

endmodule

// File: tb/tb_stepper_pulse_driver.sv
// Move-level checks of the stepper pulse driver: directed table, reset abort, random moves.
module tb_stepper_pulse_driver;
   import stepper_pkg::*;

   localparam int SP = 10;
   localparam int PH = 4;
   localparam int DS = 3;

   logic clk = 1'b0;
   logic reset;

   stepper_pulse_driver_if bus();

   stepper_pulse_driver #(
      .STEP_PERIOD (SP),
      .PULSE_HIGH  (PH),
      .DIR_SETUP   (DS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int s1;
      int s2;
      bit d1;
      bit d2;
      int off_at;
      int off_len;
      int dr_at;
      int exp_low;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Expected rise times (cycles after the load edge): one every SP after DS,
   // and anything scheduled past the pause start slips by the pause length.
   function automatic void model_rises(input int cnt, input int off_at, input int off_len,
                                       output int q[$]);
      int t;
      q = {};
      for (int i = 0; i < cnt; i++) begin
         t = DS + i * SP;
         if (off_at >= 0 && t > off_at) t += off_len;
         q.push_back(t);
      end
   endfunction

   task automatic run_move(input string tag, input int s1, input int s2, input bit d1,
                           input bit d2, input int off_at, input int off_len,
                           input int dr_at, input int exp_low);
      int r1[$], r2[$], f1[$], f2[$], e1[$], e2[$];
      int n, low_n, dir_bad, bound, bad, idle_bad;
      logic p1, p2;

      n = 0;
      while (bus.stepperReady !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s_idle_before", tag), int'(bus.stepperReady === 1'b1), 1);

      bus.steps1    = 8'(s1);
      bus.steps2    = 8'(s2);
      bus.dir1      = d1;
      bus.dir2      = d2;
      bus.dataReady = 1'b1;
      @(negedge clk);
      bus.dataReady = 1'b0;
      check($sformatf("%s_dir1", tag), int'(bus.dir1Pin), int'(d1));
      check($sformatf("%s_dir2", tag), int'(bus.dir2Pin), int'(d2));

      n = 0; low_n = 0; dir_bad = 0; p1 = 1'b0; p2 = 1'b0;
      bound = exp_low + off_len + 40;
      while (n < bound) begin
         if (bus.stepperReady === 1'b1) break;
         low_n++;
         if (bus.step1Pin && !p1) r1.push_back(n);
         if (!bus.step1Pin && p1) f1.push_back(n);
         if (bus.step2Pin && !p2) r2.push_back(n);
         if (!bus.step2Pin && p2) f2.push_back(n);
         if (bus.dir1Pin !== d1 || bus.dir2Pin !== d2) dir_bad++;
         p1 = bus.step1Pin;
         p2 = bus.step2Pin;
         if (n == off_at) bus.enable = 1'b0;
         if (off_at >= 0 && n == off_at + off_len) bus.enable = 1'b1;
         if (n == dr_at) begin
            bus.dataReady = 1'b1;
            bus.steps1    = 8'd9;
            bus.steps2    = 8'd9;
            bus.dir1      = ~d1;
            bus.dir2      = ~d2;
         end else begin
            bus.dataReady = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      bus.dataReady = 1'b0;
      bus.enable    = 1'b1;

      check($sformatf("%s_ready_low", tag), low_n, exp_low);
      check($sformatf("%s_pulses1", tag), r1.size(), s1);
      check($sformatf("%s_pulses2", tag), r2.size(), s2);

      model_rises(s1, off_at, off_len, e1);
      model_rises(s2, off_at, off_len, e2);
      bad = 0;
      for (int i = 0; i < r1.size() && i < e1.size(); i++) if (r1[i] != e1[i]) bad++;
      for (int i = 0; i < r2.size() && i < e2.size(); i++) if (r2[i] != e2[i]) bad++;
      check($sformatf("%s_rise_times_bad", tag), bad, 0);

      bad = 0;
      if (f1.size() != r1.size()) bad++;
      if (f2.size() != r2.size()) bad++;
      for (int i = 0; i < f1.size() && i < r1.size(); i++) if (f1[i] - r1[i] != PH) bad++;
      for (int i = 0; i < f2.size() && i < r2.size(); i++) if (f2[i] - r2[i] != PH) bad++;
      check($sformatf("%s_width_bad", tag), bad, 0);
      check($sformatf("%s_dir_unstable", tag), dir_bad, 0);

      idle_bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.stepperReady !== 1'b1 || bus.step1Pin !== 1'b0 || bus.step2Pin !== 1'b0)
            idle_bad++;
         if (bus.dir1Pin !== d1 || bus.dir2Pin !== d2) idle_bad++;
      end
      check($sformatf("%s_idle_after", tag), idle_bad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s1, s2, base, off_at, off_len, dr_at, wait_n;

      tbl[0] = '{s1: 3,   s2: 5, d1: 1, d2: 0, off_at: -1, off_len: 0,  dr_at: -1, exp_low: 53};
      tbl[1] = '{s1: 0,   s2: 0, d1: 0, d2: 1, off_at: -1, off_len: 0,  dr_at: -1, exp_low: 3};
      tbl[2] = '{s1: 7,   s2: 7, d1: 1, d2: 1, off_at: -1, off_len: 0,  dr_at: 20, exp_low: 73};
      tbl[3] = '{s1: 4,   s2: 2, d1: 0, d2: 1, off_at: 4,  off_len: 20, dr_at: -1, exp_low: 63};
      tbl[4] = '{s1: 1,   s2: 0, d1: 1, d2: 0, off_at: -1, off_len: 0,  dr_at: 12, exp_low: 13};
      tbl[5] = '{s1: 255, s2: 1, d1: 0, d2: 1, off_at: -1, off_len: 0,  dr_at: -1, exp_low: 2553};

      bus.dataReady = 1'b0;
      bus.steps1    = '0;
      bus.steps2    = '0;
      bus.dir1      = 1'b0;
      bus.dir2      = 1'b0;
      bus.enable    = 1'b1;
      reset         = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_ready", int'(bus.stepperReady), 1);
      check("reset_pins", int'({bus.step1Pin, bus.step2Pin, bus.dir1Pin, bus.dir2Pin}), 0);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_ready", int'(bus.stepperReady), 1);

      for (int i = 0; i < 6; i++)
         run_move($sformatf("vec%0d", i), tbl[i].s1, tbl[i].s2, tbl[i].d1, tbl[i].d2,
                  tbl[i].off_at, tbl[i].off_len, tbl[i].dr_at, tbl[i].exp_low);

      // abort a long move in the middle of a pulse
      bus.steps1    = 8'd255;
      bus.steps2    = 8'd1;
      bus.dir1      = 1'b1;
      bus.dir2      = 1'b1;
      bus.dataReady = 1'b1;
      @(negedge clk);
      bus.dataReady = 1'b0;
      wait_n = 0;
      while (bus.step1Pin !== 1'b1 && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      repeat (SP + 1) @(negedge clk);
      check("abort_pulse_high_before", int'(bus.step1Pin === 1'b1), 1);
      #2 reset = 1'b1;
      #1;
      check("abort_step_pins", int'({bus.step1Pin, bus.step2Pin}), 0);
      check("abort_ready", int'(bus.stepperReady), 1);
      check("abort_dir_pins", int'({bus.dir1Pin, bus.dir2Pin}), 0);
      @(negedge clk);
      reset = 1'b0;
      run_move("after_abort", 2, 2, 1'b0, 1'b1, -1, 0, -1, DS + 2 * SP);

      for (int k = 0; k < 10; k++) begin
         s1   = $urandom_range(0, 12);
         s2   = $urandom_range(0, 12);
         base = DS + max2(s1, s2) * SP;
         off_at = -1; off_len = 0; dr_at = -1;
         if ($urandom_range(0, 1) == 1) begin
            off_at  = $urandom_range(0, base - 1);
            off_len = $urandom_range(1, 15);
         end
         if ($urandom_range(0, 1) == 1) dr_at = $urandom_range(0, base - 1);
         run_move($sformatf("rand%0d", k), s1, s2, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), off_at, off_len, dr_at, base + off_len);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
